single_fp_multiplier: RTL and testbench

- Multi-cycle IEEE-754 binary32 multiplier with independent strobe/acknowledge handshakes on each operand and on the result.
- Used as a standalone FP arithmetic unit by upstream producers and downstream consumers.
- Processes one operation at a time through a sequential state machine.

---
 rtl/fp32_pkg.sv | 34 +++
 rtl/single_fp_multiplier_if.sv | 32 +++
 rtl/fp32_round.sv | 37 +++
 rtl/single_fp_multiplier.sv | 204 ++++++++++++++++++++
 tb/tb_single_fp_multiplier.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared types and constants for the binary32 multiplier.
//   state_t  - multiplier FSM states, in processing order
//   BIAS     - exponent bias of binary32
//   EXP_MIN  - smallest unbiased exponent of a normal number
//   EXP_MAX  - largest unbiased exponent of a finite number
//   QNAN     - canonical quiet NaN returned for invalid operations
//   POS_INF  - positive infinity encoding
// Exponents are carried as 10-bit signed values. That width covers the full
// range of an unnormalised product, from about -300 up to 256.
package fp32_pkg;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SPECIAL,
    NORM_A,
    NORM_B,
    MUL_0,
    MUL_1,
    NORM_1,
    NORM_2,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  localparam logic signed [9:0] BIAS    = 10'sd127;
  localparam logic signed [9:0] EXP_MIN = -10'sd126;
  localparam logic signed [9:0] EXP_MAX = 10'sd127;
  localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
  localparam logic [31:0]       POS_INF = 32'h7F80_0000;

endpackage

// File: rtl/single_fp_multiplier_if.sv
// single_fp_multiplier_if: operand and result handshakes of the multiplier.
//   input_a / input_a_stb / input_a_ack   operand A channel
//   input_b / input_b_stb / input_b_ack   operand B channel
//   output_z / output_z_stb / output_z_ack result channel
// Handshake rule, shared by all three channels: a word moves on a rising
// clock edge where both strobe and ack are high. The source keeps its data
// and strobe steady until that edge. The sink may raise ack whenever it is
// ready, and it drops ack in the cycle that follows the transfer.
// Modports:
//   master - producer/consumer side (drives operands, accepts result)
//   slave  - multiplier side
interface single_fp_multiplier_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/fp32_round.sv
// fp32_round: round-to-nearest-even increment of a 24-bit significand.
//   m_in      significand before rounding (bit 23 = leading bit)
//   guard     first bit below the significand
//   round_bit second bit below the significand
//   sticky    OR of all remaining lower bits
//   m_out     rounded significand
//   exp_inc   high when rounding carried out of bit 23
module fp32_round (
  input  logic [23:0] m_in,
  input  logic        guard,
  input  logic        round_bit,
  input  logic        sticky,
  output logic [23:0] m_out,
  output logic        exp_inc
);

  logic inc;

  // An exact tie (guard only) rounds up only when the significand is odd.
  assign inc = guard & (round_bit | sticky | m_in[0]);

  always_comb begin
    m_out   = m_in;
    exp_inc = 1'b0;
    if (inc) begin
      if (m_in == 24'hFF_FFFF) begin
        // The carry gives 0x1000000. Renormalised, that is 1.0 with the
        // exponent one higher.
        m_out   = 24'h80_0000;
        exp_inc = 1'b1;
      end else begin
        m_out = m_in + 24'd1;
      end
    end
  end

endmodule

// File: rtl/single_fp_multiplier.sv
// single_fp_multiplier: multi-cycle IEEE-754 binary32 multiplier. It handles
// one operation at a time, accepting A, then B, and then presenting Z.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bus       operand/result handshakes (single_fp_multiplier_if.slave)
//   state_dbg current FSM state
// Build option FLUSH_DENORM_EN: when defined, subnormal operands count as
// signed zero, and results below the normal range are packed as signed zero.
// When undefined, the design performs full gradual underflow.
module single_fp_multiplier
  import fp32_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  single_fp_multiplier_if.slave  bus,
  output state_t                 state_dbg
);

  state_t state, next_state;

  logic [31:0]       a, b, z;
  logic [23:0]       a_m, b_m, z_m;
  logic signed [9:0] a_e, b_e, z_e;
  logic              a_s, b_s, z_s;
  logic              guard, round_bit, sticky;
  logic [49:0]       product;
  logic              a_ack, b_ack, z_stb;

  // Operand classification, taken from the captured raw words
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [31:0] special_z;

  assign a_nan = (&a[30:23]) & (|a[22:0]);
  assign b_nan = (&b[30:23]) & (|b[22:0]);
  assign a_inf = (&a[30:23]) & ~(|a[22:0]);
  assign b_inf = (&b[30:23]) & ~(|b[22:0]);
`ifdef FLUSH_DENORM_EN
  assign a_zero = ~(|a[30:23]);
  assign b_zero = ~(|b[30:23]);
`else
  assign a_zero = ~(|a[30:0]);
  assign b_zero = ~(|b[30:0]);
`endif
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  always_comb begin
    special_z = {a_s ^ b_s, 31'd0};
    if (a_nan || b_nan) begin
      special_z = QNAN;
    end else if (a_inf || b_inf) begin
      if (a_zero || b_zero) special_z = QNAN;
      else                  special_z = {a_s ^ b_s, POS_INF[30:0]};
    end
  end

  // Rounding and packing
  logic [23:0]       rnd_m;
  logic              rnd_inc;
  logic signed [9:0] pack_e;
  logic [31:0]       packed_z;

  fp32_round u_round (
    .m_in      (z_m),
    .guard     (guard),
    .round_bit (round_bit),
    .sticky    (sticky),
    .m_out     (rnd_m),
    .exp_inc   (rnd_inc)
  );

  always_comb begin
    pack_e   = z_e + BIAS;
    packed_z = {z_s, pack_e[7:0], z_m[22:0]};
    // At the minimum exponent without a leading one, the value is subnormal
    if (z_e == EXP_MIN && !z_m[23]) packed_z[30:23] = 8'h00;
`ifdef FLUSH_DENORM_EN
    if (z_e < EXP_MIN) packed_z = {z_s, 31'd0};
`endif
    if (z_e > EXP_MAX) packed_z = {z_s, POS_INF[30:0]};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= GET_A;
    else     state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      GET_A:   if (a_ack && bus.input_a_stb) next_state = GET_B;
      GET_B:   if (b_ack && bus.input_b_stb) next_state = UNPACK;
      UNPACK:  next_state = SPECIAL;
      SPECIAL: next_state = special ? PUT_Z : NORM_A;
      NORM_A:  if (a_m[23]) next_state = NORM_B;
      NORM_B:  if (b_m[23]) next_state = MUL_0;
      MUL_0:   next_state = MUL_1;
      MUL_1:   next_state = NORM_1;
      NORM_1:  if (z_m[23]) next_state = NORM_2;
`ifdef FLUSH_DENORM_EN
      NORM_2:  next_state = ROUND;
`else
      NORM_2:  if (!(z_e < EXP_MIN)) next_state = ROUND;
`endif
      ROUND:   next_state = PACK;
      PACK:    next_state = PUT_Z;
      PUT_Z:   if (z_stb && bus.output_z_ack) next_state = GET_A;
      default: next_state = GET_A;
    endcase
  end

  // Datapath and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0; b <= '0; z <= '0;
      a_m <= '0; b_m <= '0; z_m <= '0;
      a_e <= '0; b_e <= '0; z_e <= '0;
      a_s <= 1'b0; b_s <= 1'b0; z_s <= 1'b0;
      guard <= 1'b0; round_bit <= 1'b0; sticky <= 1'b0;
      product <= '0;
      a_ack <= 1'b0; b_ack <= 1'b0; z_stb <= 1'b0;
    end else begin
      // Each ack rises one cycle after its GET state is entered, and drops
      // on the accepting edge. The two GET states never overlap, so the
      // acks are never high together.
      a_ack <= (state == GET_A) && !(a_ack && bus.input_a_stb);
      b_ack <= (state == GET_B) && !(b_ack && bus.input_b_stb);
      z_stb <= (state == PUT_Z) && !(z_stb && bus.output_z_ack);

      case (state)
        GET_A: if (a_ack && bus.input_a_stb) a <= bus.input_a;
        GET_B: if (b_ack && bus.input_b_stb) b <= bus.input_b;
        UNPACK: begin
          a_m <= {1'b0, a[22:0]};
          b_m <= {1'b0, b[22:0]};
          a_e <= $signed({2'b00, a[30:23]}) - BIAS;
          b_e <= $signed({2'b00, b[30:23]}) - BIAS;
          a_s <= a[31];
          b_s <= b[31];
        end
        SPECIAL: begin
          z_s <= a_s ^ b_s;
          if (special) begin
            z <= special_z;
          end else begin
            // A subnormal has no hidden one and sits at the minimum exponent
            if (a[30:23] == 8'h00) a_e <= EXP_MIN;
            else                   a_m[23] <= 1'b1;
            if (b[30:23] == 8'h00) b_e <= EXP_MIN;
            else                   b_m[23] <= 1'b1;
          end
        end
        NORM_A: if (!a_m[23]) begin
          a_m <= a_m << 1;
          a_e <= a_e - 10'sd1;
        end
        NORM_B: if (!b_m[23]) begin
          b_m <= b_m << 1;
          b_e <= b_e - 10'sd1;
        end
        MUL_0: begin
          product <= 50'(a_m) * 50'(b_m) * 50'd4;
          z_e     <= a_e + b_e + 10'sd1;
        end
        MUL_1: begin
          z_m       <= product[49:26];
          guard     <= product[25];
          round_bit <= product[24];
          sticky    <= |product[23:0];
        end
        NORM_1: if (!z_m[23]) begin
          z_m       <= {z_m[22:0], guard};
          guard     <= round_bit;
          round_bit <= 1'b0;
          z_e       <= z_e - 10'sd1;
        end
`ifndef FLUSH_DENORM_EN
        NORM_2: if (z_e < EXP_MIN) begin
          z_m       <= z_m >> 1;
          guard     <= z_m[0];
          round_bit <= guard;
          sticky    <= sticky | round_bit;
          z_e       <= z_e + 10'sd1;
        end
`endif
        ROUND: begin
          z_m <= rnd_m;
          if (rnd_inc) z_e <= z_e + 10'sd1;
        end
        PACK: z <= packed_z;
        default: ;
      endcase
    end
  end

  assign bus.input_a_ack  = a_ack;
  assign bus.input_b_ack  = b_ack;
  assign bus.output_z     = z;
  assign bus.output_z_stb = z_stb;
  assign state_dbg        = state;

endmodule

// File: tb/tb_single_fp_multiplier.sv
// tb_single_fp_multiplier: directed test of single_fp_multiplier. The bench
// applies hand-computed binary32 vectors and checks the handshakes, the
// result values, reset, and the special, overflow, subnormal and rounding
// cases.
module tb_single_fp_multiplier;
  import fp32_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  single_fp_multiplier_if bus ();
  state_t state_dbg;

  single_fp_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present both operands and complete the A then B transfers.
  // It checks the ack ordering along the way.
  task automatic send_operands(input string tag, input logic [31:0] va, input logic [31:0] vb);
    int n;
    bus.input_a = va;
    bus.input_b = vb;
    bus.input_a_stb = 1'b1;
    bus.input_b_stb = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.input_a_ack && n < 50) begin @(negedge clk); n++; end
    check({tag, " a_ack"}, 32'(bus.input_a_ack), 32'd1);
    check({tag, " b_ack idle during A"}, 32'(bus.input_b_ack), 32'd0);
    @(posedge clk); #1 bus.input_a_stb = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.input_b_ack && n < 50) begin @(negedge clk); n++; end
    check({tag, " b_ack"}, 32'(bus.input_b_ack), 32'd1);
    check({tag, " a_ack idle during B"}, 32'(bus.input_a_ack), 32'd0);
    @(posedge clk); #1 bus.input_b_stb = 1'b0;
  endtask

  // Full operation. If ack_high is set, output_z_ack is already held high
  // by the caller. Otherwise the result must hold until it is acknowledged.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp, input bit ack_high);
    int n;
    send_operands(tag, va, vb);
    n = 0;
    @(negedge clk);
    while (!bus.output_z_stb && n < 200) begin @(negedge clk); n++; end
    check({tag, " z_stb"}, 32'(bus.output_z_stb), 32'd1);
    check({tag, " z"}, bus.output_z, exp);
    if (!ack_high) begin
      repeat (2) @(negedge clk);
      check({tag, " z_stb held"}, 32'(bus.output_z_stb), 32'd1);
      check({tag, " z held"}, bus.output_z, exp);
      bus.output_z_ack = 1'b1;
      @(posedge clk); #1 bus.output_z_ack = 1'b0;
    end
    @(negedge clk);
    check({tag, " z_stb dropped"}, 32'(bus.output_z_stb), 32'd0);
    check({tag, " back to GET_A"}, 32'(state_dbg), 32'(GET_A));
  endtask

  initial begin
    int n;
    logic [31:0] exp_sub_out, exp_sub_in;
`ifdef FLUSH_DENORM_EN
    exp_sub_out = 32'h0000_0000;
    exp_sub_in  = 32'h0000_0000;
`else
    exp_sub_out = 32'h0040_0000;
    exp_sub_in  = 32'h0080_0000;
`endif
    rst = 1'b1;
    bus.input_a = '0;
    bus.input_b = '0;
    bus.input_a_stb = 1'b0;
    bus.input_b_stb = 1'b0;
    bus.output_z_ack = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("reset a_ack", 32'(bus.input_a_ack), 32'd0);
    check("reset b_ack", 32'(bus.input_b_ack), 32'd0);
    check("reset z_stb", 32'(bus.output_z_stb), 32'd0);
    check("reset z", bus.output_z, 32'd0);
    check("reset state", 32'(state_dbg), 32'(GET_A));
    @(posedge clk); #1 rst = 1'b0;

    run_op("5x3", 32'h40A0_0000, 32'h4040_0000, 32'h4170_0000, 1'b0);

    bus.output_z_ack = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    run_op("-5x7", 32'hC0A0_0000, 32'h40E0_0000, 32'hC20C_0000, 1'b1);
    bus.output_z_ack = 1'b0;

    run_op("inf x 0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0);
    run_op("-inf x 2", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
    run_op("-0 x 1", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0);
    run_op("nan x 1", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
    run_op("overflow", 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0);
    run_op("subnormal out", 32'h0080_0000, 32'h3F00_0000, exp_sub_out, 1'b0);
    run_op("subnormal in", 32'h0000_0001, 32'h4B00_0000, exp_sub_in, 1'b0);
    run_op("round sticky", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0);
    run_op("round max", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0);

    // Abort an operation during its multiply steps
    send_operands("abort", 32'h40A0_0000, 32'h4040_0000);
    n = 0;
    @(negedge clk);
    while (state_dbg != MUL_1 && n < 50) begin @(negedge clk); n++; end
    check("abort reached MUL_1", 32'(state_dbg), 32'(MUL_1));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort a_ack", 32'(bus.input_a_ack), 32'd0);
    check("abort b_ack", 32'(bus.input_b_ack), 32'd0);
    check("abort z_stb", 32'(bus.output_z_stb), 32'd0);
    check("abort z", bus.output_z, 32'd0);
    check("abort state", 32'(state_dbg), 32'(GET_A));

    run_op("after abort", 32'hC0A0_0000, 32'h40E0_0000, 32'hC20C_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
